// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI flash read path: SPI master register map,
// slave-select values, sequencer state encoding and header byte helper.
package spi_ctrl_pkg;

  // SPI master Wishbone register map
  localparam logic [7:0] CFG_ADDR   = 8'h01;
  localparam logic [7:0] DATA_ADDR  = 8'h02;

  // Values written to the config register (bit0 drives SS, active low)
  localparam logic [7:0] SS_ASSERT  = 8'h00;
  localparam logic [7:0] SS_RELEASE = 8'h01;

  // Byte shifted out while clocking in flash read data
  localparam logic [7:0] DUMMY_TX   = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SS_LOW  = 3'd1,
    ST_HDR_TX  = 3'd2,
    ST_HDR_RX  = 3'd3,
    ST_DAT_TX  = 3'd4,
    ST_DAT_RX  = 3'd5,
    ST_OUT     = 3'd6,
    ST_SS_HIGH = 3'd7
  } seq_state_e;

  // Selects address byte number 'position' (1 = least significant byte).
  function automatic logic [7:0] addr_byte(input logic [31:0] addr,
                                           input logic [2:0]  position);
    logic [5:0]  shift_s;
    logic [31:0] shifted_s;
    shift_s   = {position - 3'd1, 3'b000};
    shifted_s = addr >> shift_s;
    return shifted_s[7:0];
  endfunction

endpackage

// File: rtl/wb_single_master.sv
// Wishbone pipelined master that runs exactly one transaction at a time.
// A request is taken only while the bus is idle; done pulses in the ack
// cycle and rdata is the slave data of that same cycle.
module wb_single_master (
  input  logic       clk,
  input  logic       sresetn,
  input  logic       req,
  input  logic       req_we,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] m_wb_addr,
  output logic [7:0] m_wb_dat_m2s,
  input  logic [7:0] m_wb_dat_s2m,
  output logic       m_wb_we,
  output logic       m_wb_sel,
  output logic       m_wb_stb,
  output logic       m_wb_cyc,
  input  logic       m_wb_ack,
  input  logic       m_wb_stall
);

  logic       cyc_q,   cyc_d;
  logic       stb_q,   stb_d;
  logic       we_q,    we_d;
  logic [7:0] addr_q,  addr_d;
  logic [7:0] wdata_q, wdata_d;

  // Bus phase control: launch on request, drop stb once accepted, end on ack
  always_comb begin
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (cyc_q) begin
      if (m_wb_ack) begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        we_d  = 1'b0;
      end else if (stb_q && !m_wb_stall) begin
        stb_d = 1'b0;
      end else begin
        stb_d = stb_q;
      end
    end else if (req) begin
      cyc_d   = 1'b1;
      stb_d   = 1'b1;
      we_d    = req_we;
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end else begin
      cyc_d = 1'b0;
      stb_d = 1'b0;
    end
  end

  // Bus phase registers
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // An ack outside an open cycle is never ours
  assign done         = cyc_q & m_wb_ack;
  assign rdata        = m_wb_dat_s2m;
  assign m_wb_cyc     = cyc_q;
  assign m_wb_stb     = stb_q;
  assign m_wb_we      = we_q;
  assign m_wb_addr    = addr_q;
  assign m_wb_dat_m2s = wdata_q;
  assign m_wb_sel     = 1'b1;

endmodule

// File: rtl/spi_flash_read_sequencer.sv
// Reads cmd_len+1 bytes from a SPI flash through a Wishbone SPI master:
// SS low, opcode + address bytes, dummy-clocked data bytes streamed out on
// AXI-Stream, SS high. Each SPI byte is a TX write followed by an RX read.
module spi_flash_read_sequencer
  import spi_ctrl_pkg::*;
#(
  parameter logic [7:0] OPCODE     = 8'h03,
  parameter int         ADDR_BYTES = 3
) (
  input  logic        clk,
  input  logic        sresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  m_wb_addr,
  output logic [7:0]  m_wb_dat_m2s,
  input  logic [7:0]  m_wb_dat_s2m,
  output logic        m_wb_we,
  output logic        m_wb_sel,
  output logic        m_wb_stb,
  output logic        m_wb_cyc,
  input  logic        m_wb_ack,
  input  logic        m_wb_stall
);

  localparam logic [2:0] NADDR = 3'(ADDR_BYTES);

  seq_state_e  state_q,    state_d;
  logic [31:0] addr_q,     addr_d;
  logic [8:0]  byte_cnt_q, byte_cnt_d;   // bytes still to deliver, up to 256
  logic [2:0]  hdr_cnt_q,  hdr_cnt_d;    // header bytes already exchanged
  logic [7:0]  tdata_q,    tdata_d;

  logic        req_s;
  logic        req_we_s;
  logic [7:0]  req_addr_s;
  logic [7:0]  req_wdata_s;
  logic [7:0]  hdr_byte_s;
  logic        wb_done_s;
  logic [7:0]  wb_rdata_s;

  // Header byte currently due: opcode first, then address MSB-first
  always_comb begin
    if (hdr_cnt_q == 3'd0) begin
      hdr_byte_s = OPCODE;
    end else begin
      hdr_byte_s = addr_byte(addr_q, NADDR + 3'd1 - hdr_cnt_q);
    end
  end

  // Sequencer next state and the bus request for the current state
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    byte_cnt_d  = byte_cnt_q;
    hdr_cnt_d   = hdr_cnt_q;
    tdata_d     = tdata_q;
    req_s       = 1'b0;
    req_we_s    = 1'b0;
    req_addr_s  = DATA_ADDR;
    req_wdata_s = DUMMY_TX;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d     = cmd_addr;
          byte_cnt_d = {1'b0, cmd_len} + 9'd1;
          hdr_cnt_d  = 3'd0;
          state_d    = ST_SS_LOW;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SS_LOW: begin
        req_s       = 1'b1;
        req_we_s    = 1'b1;
        req_addr_s  = CFG_ADDR;
        req_wdata_s = SS_ASSERT;
        if (wb_done_s) begin
          state_d = ST_HDR_TX;
        end else begin
          state_d = ST_SS_LOW;
        end
      end
      ST_HDR_TX: begin
        req_s       = 1'b1;
        req_we_s    = 1'b1;
        req_wdata_s = hdr_byte_s;
        if (wb_done_s) begin
          state_d = ST_HDR_RX;
        end else begin
          state_d = ST_HDR_TX;
        end
      end
      ST_HDR_RX: begin
        req_s = 1'b1;
        if (wb_done_s) begin
          hdr_cnt_d = hdr_cnt_q + 3'd1;
          if (hdr_cnt_q == NADDR) begin
            state_d = ST_DAT_TX;
          end else begin
            state_d = ST_HDR_TX;
          end
        end else begin
          state_d = ST_HDR_RX;
        end
      end
      ST_DAT_TX: begin
        req_s    = 1'b1;
        req_we_s = 1'b1;
        if (wb_done_s) begin
          state_d = ST_DAT_RX;
        end else begin
          state_d = ST_DAT_TX;
        end
      end
      ST_DAT_RX: begin
        req_s = 1'b1;
        if (wb_done_s) begin
          tdata_d = wb_rdata_s;
          state_d = ST_OUT;
        end else begin
          state_d = ST_DAT_RX;
        end
      end
      ST_OUT: begin
        if (m_axis_tready) begin
          byte_cnt_d = byte_cnt_q - 9'd1;
          if (byte_cnt_q == 9'd1) begin
            state_d = ST_SS_HIGH;
          end else begin
            state_d = ST_DAT_TX;
          end
        end else begin
          state_d = ST_OUT;
        end
      end
      ST_SS_HIGH: begin
        req_s       = 1'b1;
        req_we_s    = 1'b1;
        req_addr_s  = CFG_ADDR;
        req_wdata_s = SS_RELEASE;
        if (wb_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SS_HIGH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and command registers
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_q    <= ST_IDLE;
      addr_q     <= 32'h0000_0000;
      byte_cnt_q <= 9'd0;
      hdr_cnt_q  <= 3'd0;
      tdata_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      hdr_cnt_q  <= hdr_cnt_d;
      tdata_q    <= tdata_d;
    end
  end

  wb_single_master u_wb (
    .clk          (clk),
    .sresetn      (sresetn),
    .req          (req_s),
    .req_we       (req_we_s),
    .req_addr     (req_addr_s),
    .req_wdata    (req_wdata_s),
    .done         (wb_done_s),
    .rdata        (wb_rdata_s),
    .m_wb_addr    (m_wb_addr),
    .m_wb_dat_m2s (m_wb_dat_m2s),
    .m_wb_dat_s2m (m_wb_dat_s2m),
    .m_wb_we      (m_wb_we),
    .m_wb_sel     (m_wb_sel),
    .m_wb_stb     (m_wb_stb),
    .m_wb_cyc     (m_wb_cyc),
    .m_wb_ack     (m_wb_ack),
    .m_wb_stall   (m_wb_stall)
  );

  // Completion coincides with the SS-release ack so busy drops in that cycle
  assign done          = (state_q == ST_SS_HIGH) && wb_done_s;
  assign busy          = (state_q != ST_IDLE) && !done;
  assign cmd_ready     = (state_q == ST_IDLE);
  assign m_axis_tvalid = (state_q == ST_OUT);
  assign m_axis_tdata  = tdata_q;

endmodule

// File: tb/tb_spi_flash_read_sequencer.sv
// Scoreboard bench: expected Wishbone transactions, stream bytes and done
// pulses are queued when a command is issued; a monitor compares them.
module tb_spi_flash_read_sequencer;

  localparam int AB = 3;

  logic        clk = 1'b0;
  logic        sresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        busy;
  logic        done;
  logic [7:0]  m_wb_addr;
  logic [7:0]  m_wb_dat_m2s;
  logic [7:0]  m_wb_dat_s2m;
  logic        m_wb_we;
  logic        m_wb_sel;
  logic        m_wb_stb;
  logic        m_wb_cyc;
  logic        m_wb_ack;
  logic        m_wb_stall;

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_wb[$];     // {sel, we, addr, data (0 for reads)}
  logic [7:0]  exp_byte[$];
  int done_exp = 0;
  int done_cnt = 0;
  int rx_cnt   = 0;
  int hold_idx = -1;
  int stall_max = 0;
  int ack_max   = 0;
  logic spur_ack = 1'b0;

  // Wishbone slave model state
  logic stall_r;
  logic pend;
  logic cur_we;
  int   cnt;
  int   cur_delay;
  int   rd_k;
  int   stall_run;

  always #5 clk = ~clk;

  spi_flash_read_sequencer #(.OPCODE(8'h03), .ADDR_BYTES(AB)) dut (
    .clk(clk), .sresetn(sresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .busy(busy), .done(done),
    .m_wb_addr(m_wb_addr), .m_wb_dat_m2s(m_wb_dat_m2s), .m_wb_dat_s2m(m_wb_dat_s2m),
    .m_wb_we(m_wb_we), .m_wb_sel(m_wb_sel), .m_wb_stb(m_wb_stb), .m_wb_cyc(m_wb_cyc),
    .m_wb_ack(m_wb_ack), .m_wb_stall(m_wb_stall)
  );

  function automatic logic [7:0] data_pat(input int i);
    return 8'(8'hA5 + 8'(i * 37));
  endfunction

  function automatic logic [7:0] rd_val(input int k);
    if (k < 1 + AB) return 8'hFF;
    else return data_pat(k - 1 - AB);
  endfunction

  assign m_wb_stall = stall_r;

  always_comb begin
    m_wb_ack = spur_ack;
    if (m_wb_cyc && ((m_wb_stb && !stall_r && cur_delay == 0) || (pend && cnt == 0)))
      m_wb_ack = 1'b1;
    m_wb_dat_s2m = m_wb_ack ? rd_val(rd_k) : 8'hEE;
  end

  always @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      stall_r <= 1'b0; pend <= 1'b0; cur_we <= 1'b0;
      cnt <= 0; cur_delay <= 0; rd_k <= 0; stall_run <= 0;
    end else begin
      if (m_wb_cyc && m_wb_stb && !stall_r) begin
        if (m_wb_we && m_wb_addr == 8'h01) rd_k <= 0;
        if (cur_delay == 0) begin
          if (!m_wb_we) rd_k <= rd_k + 1;
        end else begin
          pend <= 1'b1; cnt <= cur_delay - 1; cur_we <= m_wb_we;
        end
      end else if (pend) begin
        if (cnt == 0) begin
          pend <= 1'b0;
          if (!cur_we) rd_k <= rd_k + 1;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (stall_max > 0 && stall_run < stall_max && $urandom_range(1, 0) == 1) begin
        stall_r <= 1'b1; stall_run <= stall_run + 1;
      end else begin
        stall_r <= 1'b0; stall_run <= 0;
      end
      cur_delay <= (ack_max > 0) ? int'($urandom_range(32'(ack_max), 0)) : 0;
    end
  end

  // Monitor: samples 1 time unit after each falling edge
  initial begin
    logic [17:0] obs, e;
    logic [7:0]  eb;
    logic acc_seen, stb_bad, post_ack, post_done;
    acc_seen = 1'b0; stb_bad = 1'b0; post_ack = 1'b0; post_done = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (!sresetn) begin
        acc_seen = 1'b0; stb_bad = 1'b0; post_ack = 1'b0; post_done = 1'b0;
      end else begin
        if (m_wb_stb && acc_seen) stb_bad = 1'b1;
        if (m_wb_cyc && m_wb_stb && !m_wb_stall) begin
          obs = {m_wb_sel, m_wb_we, m_wb_addr, (m_wb_we ? m_wb_dat_m2s : 8'h00)};
          checks++;
          if (exp_wb.size() == 0) begin
            errors++; $display("FAIL wb_extra actual=%h required=none", obs);
          end else begin
            e = exp_wb.pop_front();
            if (obs !== e) begin errors++; $display("FAIL wb_txn actual=%h required=%h", obs, e); end
          end
          checks++;
          if (m_axis_tvalid) begin errors++; $display("FAIL wb_during_tvalid actual=1 required=0"); end
          acc_seen = 1'b1;
        end
        if (post_ack) begin
          checks++;
          if (m_wb_cyc) begin errors++; $display("FAIL cyc_after_ack actual=1 required=0"); end
          post_ack = 1'b0;
        end
        if (m_wb_cyc && m_wb_ack) begin
          checks++;
          if (stb_bad) begin errors++; $display("FAIL stb_after_accept actual=1 required=0"); end
          stb_bad = 1'b0; post_ack = 1'b1;
        end
        if (!m_wb_cyc) acc_seen = 1'b0;
        if (m_axis_tvalid && m_axis_tready) begin
          checks++;
          if (exp_byte.size() == 0) begin
            errors++; $display("FAIL stream_extra actual=%h required=none", m_axis_tdata);
          end else begin
            eb = exp_byte.pop_front();
            if (m_axis_tdata !== eb) begin errors++; $display("FAIL stream_byte actual=%h required=%h", m_axis_tdata, eb); end
          end
          rx_cnt++;
        end
        if (post_done) begin
          checks++;
          if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_done actual=%b required=1", cmd_ready); end
          post_done = 1'b0;
        end
        if (done) begin
          checks++;
          if (done_exp == 0 || busy || cmd_ready) begin
            errors++;
            $display("FAIL done_pulse actual=exp%0d_busy%b_ready%b required=exp>0_busy0_ready0", done_exp, busy, cmd_ready);
          end
          if (done_exp > 0) done_exp--;
          done_cnt++; post_done = 1'b1;
        end
      end
    end
  end

  // Backpressure: hold tready low for 20 cycles on stream byte hold_idx
  initial begin
    logic [7:0] snap;
    logic bad_wb, bad_d;
    int n;
    forever begin
      @(negedge clk);
      if (hold_idx >= 0 && rx_cnt == hold_idx) begin
        m_axis_tready = 1'b0;
        n = 0;
        while (!m_axis_tvalid && n < 2000) begin @(negedge clk); n++; end
        snap = m_axis_tdata; bad_wb = 1'b0; bad_d = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (m_wb_cyc || m_wb_stb) bad_wb = 1'b1;
          if (!m_axis_tvalid || m_axis_tdata !== snap) bad_d = 1'b1;
          spur_ack = (i == 10);
        end
        spur_ack = 1'b0; m_axis_tready = 1'b1; hold_idx = -1;
        checks++;
        if (bad_wb) begin errors++; $display("FAIL hold_no_wb actual=activity required=none"); end
        checks++;
        if (bad_d) begin errors++; $display("FAIL hold_tdata_stable actual=changed required=%h", snap); end
      end
    end
  end

  task automatic push_cmd(input logic [31:0] addr, input logic [7:0] len);
    logic [7:0] hb [0:3];
    hb[0] = 8'h03; hb[1] = addr[23:16]; hb[2] = addr[15:8]; hb[3] = addr[7:0];
    exp_wb.push_back({1'b1, 1'b1, 8'h01, 8'h00});
    for (int i = 0; i < 4; i++) begin
      exp_wb.push_back({1'b1, 1'b1, 8'h02, hb[i]});
      exp_wb.push_back({1'b1, 1'b0, 8'h02, 8'h00});
    end
    for (int i = 0; i <= int'(len); i++) begin
      exp_wb.push_back({1'b1, 1'b1, 8'h02, 8'h00});
      exp_wb.push_back({1'b1, 1'b0, 8'h02, 8'h00});
      exp_byte.push_back(data_pat(i));
    end
    exp_wb.push_back({1'b1, 1'b1, 8'h01, 8'h01});
    done_exp++;
  endtask

  task automatic start_cmd(input logic [31:0] addr, input logic [7:0] len);
    push_cmd(addr, len);
    rx_cnt = 0;
    @(negedge clk);
    cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int tgt);
    int n;
    n = 0;
    while (done_cnt < tgt && n < 40000) begin @(negedge clk); n++; end
    checks++;
    if (done_cnt < tgt) begin errors++; $display("FAIL done_timeout actual=%0d required=%0d", done_cnt, tgt); end
    @(negedge clk);
    checks++;
    if (exp_wb.size() != 0) begin errors++; $display("FAIL wb_left actual=%0d required=0", exp_wb.size()); end
    checks++;
    if (exp_byte.size() != 0) begin errors++; $display("FAIL bytes_left actual=%0d required=0", exp_byte.size()); end
  endtask

  task automatic run_cmd(input logic [31:0] addr, input logic [7:0] len);
    int tgt;
    tgt = done_cnt + 1;
    start_cmd(addr, len);
    wait_done(tgt);
  endtask

  initial begin
    int n, tgt;
    sresetn = 1'b0; cmd_valid = 1'b0; cmd_addr = 32'h0; cmd_len = 8'h00;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_wb_cyc, m_wb_stb, m_wb_we, m_axis_tvalid, busy, done} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs actual=%b required=000000", {m_wb_cyc, m_wb_stb, m_wb_we, m_axis_tvalid, busy, done});
    end
    sresetn = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready actual=%b required=1", cmd_ready); end

    // Single byte read, zero wait
    run_cmd(32'h0001_2345, 8'h00);

    // 256-byte read
    run_cmd(32'h00AB_CDEF, 8'hFF);
    checks++;
    if (rx_cnt != 256) begin errors++; $display("FAIL stream_count_256 actual=%0d required=256", rx_cnt); end

    // Backpressure on third byte of five
    hold_idx = 2;
    run_cmd(32'h0010_0000, 8'h04);
    checks++;
    if (rx_cnt != 5) begin errors++; $display("FAIL stream_count_5 actual=%0d required=5", rx_cnt); end

    // Random stall / ack latency
    stall_max = 5; ack_max = 7;
    run_cmd(32'h0001_2345, 8'h00);
    run_cmd(32'h00FE_DCBA, 8'h03);

    // Reset while reading data byte 2
    start_cmd(32'h0077_7777, 8'h03);
    n = 0;
    while (!(rx_cnt >= 1 && m_wb_cyc && !m_wb_we) && n < 5000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 5000) begin errors++; $display("FAIL reach_dat_rx actual=timeout required=reached"); end
    #2 sresetn = 1'b0;
    #1;
    checks++;
    if ({m_wb_cyc, m_wb_stb, m_wb_we, m_axis_tvalid, busy, done} !== 6'b0) begin
      errors++; $display("FAIL reset_mid_outputs actual=%b required=000000", {m_wb_cyc, m_wb_stb, m_wb_we, m_axis_tvalid, busy, done});
    end
    exp_wb.delete(); exp_byte.delete(); done_exp = 0;
    repeat (2) @(negedge clk);
    sresetn = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset actual=%b required=1", cmd_ready); end
    run_cmd(32'h0001_2345, 8'h00);

    // cmd_valid while busy is ignored
    stall_max = 0; ack_max = 0;
    tgt = done_cnt + 1;
    start_cmd(32'h0000_1234, 8'h01);
    repeat (4) @(negedge clk);
    cmd_addr = 32'h00FF_FFFF; cmd_len = 8'h10; cmd_valid = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL ignore_while_busy actual=ready%b_busy%b required=ready0_busy1", cmd_ready, busy);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(tgt);
    repeat (20) @(negedge clk);
    checks++;
    if (m_wb_cyc !== 1'b0 || done_cnt != tgt) begin
      errors++; $display("FAIL no_second_transfer actual=cyc%b_done%0d required=cyc0_done%0d", m_wb_cyc, done_cnt, tgt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
